// File: rtl/spi_xfer_fsm.sv
//------------------------------------------------------------------------------
// Module      : spi_xfer_fsm
// Description : SPI slave transaction sequencer with configurable address/data
//               widths; optional burst mode enabled by defining SPI_BURST_EN.
// Revision    : 1.0 - initial parametrised release
//------------------------------------------------------------------------------
`default_nettype none

module spi_xfer_fsm #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic positiveedge_sclk,
  input  logic negativeedge_sclk,
  input  logic cs,
  input  logic mosi,
  output logic MISO_BUF,
  output logic ADDR_WE,
  output logic SR_WE,
  output logic DM_WE,
  output logic ADDR_INC
);

  localparam int c_CNT_MAX = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;
  localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_W);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_RW_DEC, S_RD_LOAD, S_RD_SHIFT,
    S_WR_SHIFT, S_WR_COMMIT, S_NEXT, S_DONE
  } state_t;

`ifdef SPI_BURST_EN
  localparam state_t c_AFTER_WORD = S_NEXT;
`else
  localparam state_t c_AFTER_WORD = S_DONE;
`endif

  state_t             r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_rw, w_rw_nxt;
  logic               w_sr_we;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rw_nxt    = r_rw;
    w_sr_we     = 1'b0;
    case (r_state)
      S_IDLE:      w_state_nxt = S_ADDR;
      S_ADDR: begin
        if (positiveedge_sclk) begin
          if (r_cnt == c_ADDR_LAST) begin
            w_state_nxt = S_RW_DEC;
            w_rw_nxt    = mosi;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_RW_DEC:    w_state_nxt = r_rw ? S_RD_LOAD : S_WR_SHIFT;
      // A simultaneous positive edge masks the falling edge
      S_RD_LOAD: begin
        if (negativeedge_sclk && !positiveedge_sclk) begin
          w_state_nxt = S_RD_SHIFT;
          w_sr_we     = 1'b1;
        end
      end
      S_RD_SHIFT: begin
        if (r_cnt == c_DATA_LAST)   w_state_nxt = c_AFTER_WORD;
        else if (positiveedge_sclk) w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_WR_SHIFT: begin
        if (r_cnt == c_DATA_LAST)   w_state_nxt = S_WR_COMMIT;
        else if (positiveedge_sclk) w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_WR_COMMIT: w_state_nxt = c_AFTER_WORD;
      S_NEXT:      w_state_nxt = r_rw ? S_RD_LOAD : S_WR_SHIFT;
      S_DONE:      w_state_nxt = S_DONE;
      default:     w_state_nxt = S_IDLE;
    endcase
    // Deselect overrides everything, including a word-terminating edge
    if (cs) begin
      w_state_nxt = S_IDLE;
      w_sr_we     = 1'b0;
    end
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rw     <= 1'b0;
      MISO_BUF <= 1'b0;
      ADDR_WE  <= 1'b0;
      SR_WE    <= 1'b0;
      DM_WE    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rw     <= w_rw_nxt;
      MISO_BUF <= (w_state_nxt == S_RD_SHIFT);
      ADDR_WE  <= (w_state_nxt == S_RW_DEC);
      SR_WE    <= w_sr_we;
      DM_WE    <= (w_state_nxt == S_WR_COMMIT);
    end
  end

`ifdef SPI_BURST_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ADDR_INC <= 1'b0;
    else          ADDR_INC <= (w_state_nxt == S_NEXT);
  end
`else
  assign ADDR_INC = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_xfer_fsm.sv
//------------------------------------------------------------------------------
// Module      : tb_spi_xfer_fsm
// Description : Bench for spi_xfer_fsm at 7/8 and 4/16 widths on one shared
//               SCLK stream; expected strobe cycles derived from pulse times.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_xfer_fsm;

  localparam int MAXT = 1024;
  localparam int MAXP = 128;
`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0, pos = 1'b0, neg = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic a_miso, a_awe, a_srwe, a_dmwe, a_inc;
  logic b_miso, b_awe, b_srwe, b_dmwe, b_inc;

  always #5 clk = ~clk;

  spi_xfer_fsm #(.ADDR_W(7), .DATA_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .positiveedge_sclk(pos), .negativeedge_sclk(neg),
    .cs(cs), .mosi(mosi), .MISO_BUF(a_miso), .ADDR_WE(a_awe), .SR_WE(a_srwe),
    .DM_WE(a_dmwe), .ADDR_INC(a_inc));

  spi_xfer_fsm #(.ADDR_W(4), .DATA_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .positiveedge_sclk(pos), .negativeedge_sclk(neg),
    .cs(cs), .mosi(mosi), .MISO_BUF(b_miso), .ADDR_WE(b_awe), .SR_WE(b_srwe),
    .DM_WE(b_dmwe), .ADDR_INC(b_inc));

  int vectors = 0, miscompares = 0;

  // Pulse schedule of the current transaction (cycle numbers relative to its start)
  int pos_t[MAXP];
  bit pos_mosi[MAXP];
  int neg_t[MAXP];
  int npos, nneg, tc, tend;
  bit c_pos[MAXT], c_neg[MAXT], c_mosi[MAXT];

  // Expected outputs per instance, indexed by the cycle whose clock edge updates them
  bit e_awe[2][MAXT], e_srwe[2][MAXT], e_dmwe[2][MAXT], e_inc[2][MAXT], e_miso[2][MAXT];

  task automatic check(input string tag, input logic obs, input logic exp_v, input int t);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s t=%0d: observed %b expected %b", tag, t, obs, exp_v);
    end
  endtask

  task automatic check_all(input int t, input bit zero);
    check("A.MISO_BUF", a_miso, zero ? 1'b0 : e_miso[0][t], t);
    check("A.ADDR_WE",  a_awe,  zero ? 1'b0 : e_awe[0][t],  t);
    check("A.SR_WE",    a_srwe, zero ? 1'b0 : e_srwe[0][t], t);
    check("A.DM_WE",    a_dmwe, zero ? 1'b0 : e_dmwe[0][t], t);
    check("A.ADDR_INC", a_inc,  zero ? 1'b0 : e_inc[0][t],  t);
    check("B.MISO_BUF", b_miso, zero ? 1'b0 : e_miso[1][t], t);
    check("B.ADDR_WE",  b_awe,  zero ? 1'b0 : e_awe[1][t],  t);
    check("B.SR_WE",    b_srwe, zero ? 1'b0 : e_srwe[1][t], t);
    check("B.DM_WE",    b_dmwe, zero ? 1'b0 : e_dmwe[1][t], t);
    check("B.ADDR_INC", b_inc,  zero ? 1'b0 : e_inc[1][t],  t);
  endtask

  // Alternating pos/neg pulses 3..5 cycles apart; index 7 and 4 carry the R/W bits
  task automatic gen(input int np, input bit rw_a, input bit rw_b, input bit cs_same);
    int t;
    for (int i = 0; i < MAXT; i++) begin
      c_pos[i] = 1'b0; c_neg[i] = 1'b0; c_mosi[i] = 1'b0;
    end
    t = 2; npos = np; nneg = 0;
    for (int i = 0; i < np; i++) begin
      pos_t[i]    = t;
      pos_mosi[i] = (i == 7) ? rw_a : (i == 4) ? rw_b : 1'($urandom);
      c_pos[t]    = 1'b1;
      c_mosi[t]   = pos_mosi[i];
      t += int'($urandom_range(3, 5));
      if (!(cs_same && i == np - 1)) begin
        neg_t[nneg] = t; nneg++;
        c_neg[t] = 1'b1;
        t += int'($urandom_range(3, 5));
      end
    end
    if (cs_same && np > 0) tc = pos_t[np-1];
    else                   tc = t + int'($urandom_range(0, 3));
    c_pos[tc+2]  = 1'b1;
    c_mosi[tc+2] = 1'($urandom);
    tend = tc + 4;
  endtask

  // Word-level view: an output event at cycle x only survives if x < tlim
  task automatic model(input int ki, input int aw, input int dw, input int tlim);
    int k, j, s, t1, t2, t3, tn;
    bit rw;
    for (int t = 0; t < MAXT; t++) begin
      e_awe[ki][t] = 0; e_srwe[ki][t] = 0; e_dmwe[ki][t] = 0; e_inc[ki][t] = 0; e_miso[ki][t] = 0;
    end
    if (npos <= aw) return;
    t1 = pos_t[aw];
    if (t1 < tlim) e_awe[ki][t1] = 1'b1;
    rw = pos_mosi[aw];
    k  = aw + 1;
    s  = t1 + 1;
    if (!rw) begin
      forever begin
        while (k < npos && pos_t[k] <= s) k++;
        if (k + dw > npos) break;
        t2 = pos_t[k+dw-1];
        k += dw;
        if (t2 + 1 < tlim) e_dmwe[ki][t2+1] = 1'b1;
        if (!BURST) break;
        if (t2 + 2 < tlim) e_inc[ki][t2+2] = 1'b1;
        s = t2 + 3;
      end
    end else begin
      j = 0;
      forever begin
        while (j < nneg && neg_t[j] <= s) j++;
        if (j >= nneg) break;
        tn = neg_t[j];
        if (tn < tlim) e_srwe[ki][tn] = 1'b1;
        while (k < npos && pos_t[k] <= tn) k++;
        t3 = (k + dw > npos) ? MAXT - 1 : pos_t[k+dw-1];
        for (int t = tn; t <= t3 && t < tlim; t++) e_miso[ki][t] = 1'b1;
        if (k + dw > npos) break;
        k += dw;
        if (!BURST) break;
        if (t3 + 1 < tlim) e_inc[ki][t3+1] = 1'b1;
        s = t3 + 2;
      end
    end
  endtask

  task automatic run(input int np, input bit rw_a, input bit rw_b, input bit cs_same,
                     input int rst_at);
    int tlim;
    gen(np, rw_a, rw_b, cs_same);
    tlim = (rst_at >= 0 && rst_at < tc) ? rst_at : tc;
    model(0, 7, 8, tlim);
    model(1, 4, 16, tlim);
    for (int t = 0; t < tend; t++) begin
      @(negedge clk);
      cs   = (t < tc) ? 1'b0 : 1'b1;
      pos  = c_pos[t];
      neg  = c_neg[t];
      mosi = c_mosi[t];
      if (t == rst_at) begin
        reset_n = 1'b0;
        #1;
        check_all(t, 1'b1);
      end
      @(posedge clk);
      #1;
      check_all(t, 1'b0);
    end
    if (!reset_n) begin
      @(negedge clk);
      pos = 1'b0; neg = 1'b0;
      reset_n = 1'b1;
    end
  endtask

  initial begin
    // Reset held with the bus active: outputs must stay low
    reset_n = 1'b0;
    cs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pos  = (i % 3 == 0);
      neg  = (i % 3 == 1);
      mosi = 1'($urandom);
      @(posedge clk);
      #1;
      check_all(i, 1'b1);
    end
    @(negedge clk);
    cs = 1'b1; pos = 1'b0; neg = 1'b0; reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_all(i, 1'b1);
    end

    run(16, 1'b0, 1'b0, 1'b0, -1);  // single write word
    run(16, 1'b1, 1'b1, 1'b0, -1);  // single read word
    run(13, 1'b0, 1'b0, 1'b0, -1);  // write aborted after 5 data bits
    run(16, 1'b0, 1'b0, 1'b0, -1);  // recovery after abort
    run(8,  1'b0, 1'b0, 1'b1, -1);  // cs rises with the R/W pulse
    run(16, 1'b0, 1'b1, 1'b1, -1);  // cs rises with the last data pulse
    run(32, 1'b0, 1'b0, 1'b0, -1);  // three write words
    run(32, 1'b1, 1'b0, 1'b0, -1);  // three read words
    run(21, 1'b1, 1'b0, 1'b0, -1);  // 4/16 write word
    run(21, 1'b0, 1'b1, 1'b0, -1);  // 4/16 read word
    run(53, 1'b0, 1'b0, 1'b0, -1);  // 4/16 three write words
    run(24, 1'b1, 1'b1, 1'b0, 60);  // reset mid-transfer
    run(16, 1'b1, 1'b0, 1'b0, -1);  // recovery after reset

    for (int n = 0; n < 25; n++) begin
      run(int'($urandom_range(0, 56)), 1'($urandom), 1'($urandom),
          $urandom_range(0, 3) == 0,
          ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 100)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
